// File: rtl/hasti_apb_bridge_if.sv
// Signal bundle between one Hasti (AHB-Lite) slave port and an APB4 peripheral segment.
// The bridge takes the slave modport; the surrounding environment takes the master modport.
interface hasti_apb_bridge_if #(
  parameter int ADDR_W = 16
);
  logic [31:0]       haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [1:0]        htrans;
  logic [31:0]       hwdata;
  logic              hsel;
  logic              hreadyin;
  logic [31:0]       hrdata;
  logic              hreadyout;
  logic              hresp;

  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport slave (
    input  haddr, hwrite, hsize, htrans, hwdata, hsel, hreadyin,
    output hrdata, hreadyout, hresp,
    output paddr, pwrite, psel, penable, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport master (
    output haddr, hwrite, hsize, htrans, hwdata, hsel, hreadyin,
    input  hrdata, hreadyout, hresp,
    input  paddr, pwrite, psel, penable, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/hasti_apb_bridge.sv
// AHB-Lite (Hasti) slave to APB4 master bridge: one APB SETUP/ACCESS per AHB transfer,
// with AHB wait states held until the APB side completes, errors or times out.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no transfer pending, ready for a new address phase
// S_WDATA  | write accepted, latching hwdata from the AHB data phase
// S_SETUP  | APB setup cycle (psel=1, penable=0)
// S_ACCESS | APB access cycle, waiting for pready or timeout
// S_ERR1   | first cycle of the two-cycle AHB ERROR response
// S_ERR2   | second cycle of the ERROR response; new address ignored
module hasti_apb_bridge #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 256
) (
  input logic               clk,
  input logic               reset,
  hasti_apb_bridge_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  state_e            accept_ns;

  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [3:0]        pstrb_q, pstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  logic              hreadyout;
  logic              hresp;
  logic              psel;
  logic              penable;

  logic              accept;
  logic              take;
  logic              req_err;
  logic [3:0]        req_strb;
  logic              timeout_hit;

  logic              unused_htrans;
  assign unused_htrans = bus.htrans[0];

  if (ADDR_W < 32) begin : g_unused_addr
    logic unused_haddr;
    assign unused_haddr = ^bus.haddr[31:ADDR_W];
  end

  // ERR2 drives hreadyout high but the address offered there is dropped
  assign accept = bus.hsel & bus.hreadyin & bus.htrans[1] & hreadyout;
  assign take   = accept & (state_q != S_ERR2);

  always_comb begin
    req_err = 1'b0;
    case (bus.hsize)
      3'd0:    req_err = 1'b0;
      3'd1:    req_err = bus.haddr[0];
      3'd2:    req_err = |bus.haddr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    req_strb = 4'b1111;
    case (bus.hsize)
      3'd0:    req_strb = 4'b0001 << bus.haddr[1:0];
      3'd1:    req_strb = bus.haddr[1] ? 4'b1100 : 4'b0011;
      default: req_strb = 4'b1111;
    endcase
  end

  always_comb begin
    if (req_err) begin
      accept_ns = S_ERR1;
    end else if (bus.hwrite) begin
      accept_ns = S_WDATA;
    end else begin
      accept_ns = S_SETUP;
    end
  end

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = accept_ns;
        end
      end
      S_WDATA:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.pready) begin
          if (bus.pslverr) begin
            state_d = S_ERR1;
          end else if (take) begin
            state_d = accept_ns;
          end else begin
            state_d = S_IDLE;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    hreadyout = 1'b0;
    hresp     = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state_q)
      S_IDLE:   hreadyout = 1'b1;
      S_WDATA:  hreadyout = 1'b0;
      S_SETUP:  psel = 1'b1;
      S_ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        hreadyout = bus.pready & ~bus.pslverr;
      end
      S_ERR1:   hresp = 1'b1;
      S_ERR2: begin
        hreadyout = 1'b1;
        hresp     = 1'b1;
      end
      default:  hreadyout = 1'b1;
    endcase
  end

  // Capture only legal requests so an error leaves the previous APB request visible
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    pwdata_d = pwdata_q;
    if (take && !req_err) begin
      paddr_d  = bus.haddr[ADDR_W-1:0];
      pwrite_d = bus.hwrite;
      pstrb_d  = bus.hwrite ? req_strb : 4'b0000;
    end
    if (state_q == S_WDATA) begin
      pwdata_d = bus.hwdata;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == S_SETUP) begin
      cnt_d = '0;
    end else if ((state_q == S_ACCESS) && !bus.pready && (TIMEOUT != 0)) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= 4'b0000;
      cnt_q    <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.hrdata    = bus.prdata;
  assign bus.hreadyout = hreadyout;
  assign bus.hresp     = hresp;
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.psel      = psel;
  assign bus.penable   = penable;

  a_req_stable: assert property (@(posedge clk) disable iff (reset)
    ((state_q == S_SETUP || state_q == S_ACCESS) && state_d == S_ACCESS)
      |=> $stable({paddr_q, pwrite_q, pstrb_q, pwdata_q}));

  a_enable_needs_sel: assert property (@(posedge clk) disable iff (reset)
    penable |-> psel);

endmodule

// File: tb/tb_hasti_apb_bridge.sv
// Self-checking bench for hasti_apb_bridge: scripted AHB master, reactive APB slave,
// queue of expected APB/AHB completions popped when the bridge reports ready.
module tb_hasti_apb_bridge;

  localparam int ADDR_W = 16;
  localparam int TMO    = 4;

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic        resp;
    logic        act;
  } exp_t;

  logic clk;
  logic reset;

  hasti_apb_bridge_if #(.ADDR_W(ADDR_W)) bif ();

  hasti_apb_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  assign bif.hreadyin = bif.hreadyout;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        sb[$];

  int          apb_wait  = 0;
  logic        apb_err   = 1'b0;
  logic        apb_stuck = 1'b0;
  logic [31:0] apb_rdata = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // APB slave: answers after apb_wait not-ready ACCESS cycles
  initial begin
    int acc_n;
    acc_n       = 0;
    bif.pready  = 1'b0;
    bif.pslverr = 1'b0;
    bif.prdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (bif.psel && bif.penable) begin
        if (!apb_stuck && acc_n >= apb_wait) begin
          bif.pready  = 1'b1;
          bif.pslverr = apb_err;
          bif.prdata  = apb_rdata;
        end else begin
          bif.pready  = 1'b0;
          bif.pslverr = 1'b0;
        end
        acc_n++;
      end else begin
        bif.pready  = 1'b0;
        bif.pslverr = 1'b0;
        acc_n       = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic ahb_addr(input logic [31:0] a, input logic w, input logic [2:0] s);
    bif.hsel   = 1'b1;
    bif.htrans = 2'b10;
    bif.haddr  = a;
    bif.hwrite = w;
    bif.hsize  = s;
  endtask

  task automatic ahb_idle();
    bif.hsel   = 1'b0;
    bif.htrans = 2'b00;
  endtask

  task automatic apb_cfg(input int w, input logic e, input logic [31:0] d, input logic stuck);
    apb_wait  = w;
    apb_err   = e;
    apb_rdata = d;
    apb_stuck = stuck;
  endtask

  // Crosses the address phase, drives write data, then waits for hreadyout
  task automatic wait_done(input logic [31:0] wd, output int lows);
    lows = 0;
    step();
    ahb_idle();
    bif.hwdata = wd;
    while (bif.hreadyout !== 1'b1 && lows < 40) begin
      lows++;
      step();
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.addr = bif.paddr;
    o.wr   = bif.pwrite;
    o.strb = bif.pstrb;
    o.data = bif.pwrite ? bif.pwdata : bif.hrdata;
    o.resp = bif.hresp;
    o.act  = bif.psel & bif.penable & bif.hreadyout;
    return o;
  endfunction

  function automatic logic [3:0] model_strb(input logic [15:0] a, input logic [2:0] sz,
                                            input logic wr);
    logic [3:0] s;
    if (!wr) return 4'b0000;
    if (sz == 3'd0) begin
      case (a[1:0])
        2'd0: s = 4'b0001;
        2'd1: s = 4'b0010;
        2'd2: s = 4'b0100;
        default: s = 4'b1000;
      endcase
    end else if (sz == 3'd1) begin
      s = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      s = 4'b1111;
    end
    return s;
  endfunction

  function automatic logic model_bad(input logic [15:0] a, input logic [2:0] sz);
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    ahb_addr(32'h0000_1234, 1'b1, 3'd2);
    step();
    step();
    n_checks++;
    if ({bif.hreadyout, bif.hresp, bif.psel, bif.penable} !== 4'b1000) begin
      $display("FAIL rst_ctrl: got %b want 1000", {bif.hreadyout, bif.hresp, bif.psel, bif.penable});
    end else n_pass++;
    n_checks++;
    if ({bif.paddr, bif.pwrite, bif.pwdata, bif.pstrb} !== '0) begin
      $display("FAIL rst_regs: got paddr=%h pwrite=%b pwdata=%h pstrb=%b want all zero",
               bif.paddr, bif.pwrite, bif.pwdata, bif.pstrb);
    end else n_pass++;
    ahb_idle();
    reset = 1'b0;
    step();
  endtask

  task automatic test_read();
    exp_t e;
    apb_cfg(0, 1'b0, 32'hCAFE_F00D, 1'b0);
    sb.push_back('{16'h0010, 1'b0, 4'b0000, 32'hCAFE_F00D, 1'b0, 1'b1});
    ahb_addr(32'h4000_0010, 1'b0, 3'd2);
    step();
    ahb_idle();
    n_checks++;
    if ({bif.psel, bif.penable, bif.hreadyout} !== 3'b100) begin
      $display("FAIL rd_setup: got %b want 100", {bif.psel, bif.penable, bif.hreadyout});
    end else n_pass++;
    n_checks++;
    if (bif.paddr !== 16'h0010) begin
      $display("FAIL rd_paddr: got %h want 0010", bif.paddr);
    end else n_pass++;
    step();
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e) begin
      $display("FAIL rd_access: got %h want %h", observe(), e);
    end else n_pass++;
    step();
    n_checks++;
    if ({bif.hreadyout, bif.psel} !== 2'b10) begin
      $display("FAIL rd_idle: got %b want 10", {bif.hreadyout, bif.psel});
    end else n_pass++;
  endtask

  task automatic test_write_byte();
    exp_t e;
    int   lows;
    apb_cfg(3, 1'b0, 32'h0, 1'b0);
    sb.push_back('{16'h0003, 1'b1, 4'b1000, 32'hAB00_0000, 1'b0, 1'b1});
    ahb_addr(32'h0000_0003, 1'b1, 3'd0);
    wait_done(32'hAB00_0000, lows);
    n_checks++;
    if (lows !== 5) begin
      $display("FAIL wr_wait: got %0d want 5", lows);
    end else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e) begin
      $display("FAIL wr_access: got %h want %h", observe(), e);
    end else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lows;
    apb_cfg(0, 1'b0, 32'h1234_5678, 1'b0);
    sb.push_back('{16'h0100, 1'b0, 4'b0000, 32'h1234_5678, 1'b0, 1'b1});
    sb.push_back('{16'h0104, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b1});
    ahb_addr(32'h0000_0100, 1'b0, 3'd2);
    wait_done(32'h0, lows);
    n_checks++;
    if (lows !== 1) begin
      $display("FAIL b2b_rd_wait: got %0d want 1", lows);
    end else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e) begin
      $display("FAIL b2b_rd: got %h want %h", observe(), e);
    end else n_pass++;
    ahb_addr(32'h0000_0104, 1'b1, 3'd2);
    wait_done(32'hDEAD_BEEF, lows);
    n_checks++;
    if (lows !== 2) begin
      $display("FAIL b2b_wr_wait: got %0d want 2", lows);
    end else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (observe() !== e) begin
      $display("FAIL b2b_wr: got %h want %h", observe(), e);
    end else n_pass++;
    step();
  endtask

  task automatic test_slverr();
    apb_cfg(1, 1'b1, 32'h0, 1'b0);
    ahb_addr(32'h0000_0200, 1'b0, 3'd2);
    step();
    ahb_idle();
    step();
    step();
    n_checks++;
    if ({bif.psel, bif.penable, bif.hreadyout, bif.hresp} !== 4'b1100) begin
      $display("FAIL err_access: got %b want 1100",
               {bif.psel, bif.penable, bif.hreadyout, bif.hresp});
    end else n_pass++;
    step();
    n_checks++;
    if ({bif.hreadyout, bif.hresp, bif.psel, bif.penable} !== 4'b0100) begin
      $display("FAIL err_err1: got %b want 0100", {bif.hreadyout, bif.hresp, bif.psel, bif.penable});
    end else n_pass++;
    step();
    n_checks++;
    if ({bif.hreadyout, bif.hresp, bif.psel, bif.penable} !== 4'b1100) begin
      $display("FAIL err_err2: got %b want 1100", {bif.hreadyout, bif.hresp, bif.psel, bif.penable});
    end else n_pass++;
    ahb_addr(32'h0000_0208, 1'b0, 3'd2);
    step();
    ahb_idle();
    n_checks++;
    if ({bif.hreadyout, bif.hresp, bif.psel, bif.penable} !== 4'b1000) begin
      $display("FAIL err2_ignore: got %b want 1000", {bif.hreadyout, bif.hresp, bif.psel, bif.penable});
    end else n_pass++;
    apb_cfg(0, 1'b0, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_timeout();
    int n;
    apb_cfg(0, 1'b0, 32'h0, 1'b1);
    ahb_addr(32'h0000_0300, 1'b0, 3'd2);
    step();
    ahb_idle();
    step();
    n = 0;
    while (bif.psel === 1'b1 && bif.penable === 1'b1 && n < 20) begin
      n++;
      step();
    end
    n_checks++;
    if (n !== TMO) begin
      $display("FAIL tmo_cycles: got %0d want %0d", n, TMO);
    end else n_pass++;
    n_checks++;
    if ({bif.hreadyout, bif.hresp, bif.psel, bif.penable} !== 4'b0100) begin
      $display("FAIL tmo_err1: got %b want 0100", {bif.hreadyout, bif.hresp, bif.psel, bif.penable});
    end else n_pass++;
    step();
    n_checks++;
    if ({bif.hreadyout, bif.hresp, bif.psel, bif.penable} !== 4'b1100) begin
      $display("FAIL tmo_err2: got %b want 1100", {bif.hreadyout, bif.hresp, bif.psel, bif.penable});
    end else n_pass++;
    apb_stuck = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_access();
    logic psel_seen;
    apb_cfg(5, 1'b0, 32'h0, 1'b0);
    ahb_addr(32'h0000_0400, 1'b0, 3'd2);
    step();
    ahb_idle();
    step();
    n_checks++;
    if ({bif.psel, bif.penable} !== 2'b11) begin
      $display("FAIL rma_in_access: got %b want 11", {bif.psel, bif.penable});
    end else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({bif.hreadyout, bif.hresp, bif.psel, bif.penable} !== 4'b1000 || bif.paddr !== 16'h0) begin
      $display("FAIL rma_idle: got ctrl=%b paddr=%h want ctrl=1000 paddr=0000",
               {bif.hreadyout, bif.hresp, bif.psel, bif.penable}, bif.paddr);
    end else n_pass++;
    apb_cfg(0, 1'b0, 32'h0, 1'b0);
    ahb_addr(32'h0000_0001, 1'b0, 3'd1);
    step();
    ahb_idle();
    psel_seen = bif.psel;
    n_checks++;
    if ({bif.hreadyout, bif.hresp} !== 2'b01) begin
      $display("FAIL mis_err1: got %b want 01", {bif.hreadyout, bif.hresp});
    end else n_pass++;
    step();
    psel_seen |= bif.psel;
    n_checks++;
    if ({bif.hreadyout, bif.hresp} !== 2'b11) begin
      $display("FAIL mis_err2: got %b want 11", {bif.hreadyout, bif.hresp});
    end else n_pass++;
    step();
    psel_seen |= bif.psel;
    n_checks++;
    if (psel_seen !== 1'b0) begin
      $display("FAIL mis_psel: got %b want 0", psel_seen);
    end else n_pass++;
  endtask

  task automatic test_strobes();
    logic [15:0] t_addr [10] = '{16'h0010, 16'h0011, 16'h0012, 16'h0012, 16'h0020,
                                 16'h0024, 16'h0028, 16'h0030, 16'h0032, 16'h0023};
    logic [2:0]  t_size [10] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd3, 3'd2, 3'd1};
    logic        t_wr   [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t        e;
    int          lows;
    logic [31:0] d;
    for (int i = 0; i < 10; i++) begin
      if (model_bad(t_addr[i], t_size[i])) begin
        ahb_addr({16'h0, t_addr[i]}, t_wr[i], t_size[i]);
        step();
        ahb_idle();
        n_checks++;
        if ({bif.hreadyout, bif.hresp, bif.psel} !== 3'b010) begin
          $display("FAIL strb_err1[%0d]: got %b want 010", i, {bif.hreadyout, bif.hresp, bif.psel});
        end else n_pass++;
        step();
        n_checks++;
        if ({bif.hreadyout, bif.hresp, bif.psel} !== 3'b110) begin
          $display("FAIL strb_err2[%0d]: got %b want 110", i, {bif.hreadyout, bif.hresp, bif.psel});
        end else n_pass++;
        step();
      end else begin
        d = $urandom;
        apb_cfg(0, 1'b0, d, 1'b0);
        sb.push_back('{t_addr[i], t_wr[i], model_strb(t_addr[i], t_size[i], t_wr[i]), d, 1'b0, 1'b1});
        ahb_addr({16'h0, t_addr[i]}, t_wr[i], t_size[i]);
        wait_done(d, lows);
        n_checks++;
        if (lows !== (t_wr[i] ? 2 : 1)) begin
          $display("FAIL strb_wait[%0d]: got %0d want %0d", i, lows, t_wr[i] ? 2 : 1);
        end else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (observe() !== e) begin
          $display("FAIL strb_xfer[%0d]: got %h want %h", i, observe(), e);
        end else n_pass++;
        step();
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    bif.hsel   = 1'b0;
    bif.htrans = 2'b00;
    bif.haddr  = 32'h0;
    bif.hwrite = 1'b0;
    bif.hsize  = 3'd0;
    bif.hwdata = 32'h0;
    test_reset();
    test_read();
    test_write_byte();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_mid_access();
    test_strobes();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
